// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared OCW2 command codes, arbiter FSM state type and rotate helpers
package pic_pkg;

  localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Rotations over the low w bits of a 32-bit carrier; requires 0 <= k < w <= 32.
  // rot_right brings bit k to position 0; rot_left is its inverse.
  function automatic logic [31:0] rot_right(input logic [31:0] v, input int k, input int w);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        s = i + k;
        if (s >= w) s = s - w;
        r[i] = v[s[4:0]];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_left(input logic [31:0] v, input int k, input int w);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        s = i - k;
        if (s < 0) s = s + w;
        r[i] = v[s[4:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_rot_prio_find.sv
// rtl/pic_rot_prio_find.sv - finds the highest-priority set bit under rotating priority
module pic_rot_prio_find
  import pic_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] lowest_prio_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [31:0] rot;
  int          hi;
  int          pos;
  int          sum;

  // Rotate so the highest-priority level sits at bit 0, take the lowest set bit, then map back.
  always_comb begin
    hi  = (int'(lowest_prio_i) == N - 1) ? 0 : int'(lowest_prio_i) + 1;
    rot = rot_right(32'(vec_i), hi, N);
    pos = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    sum = pos + hi;
    if (sum >= N) sum = sum - N;
    found_o = |vec_i;
    idx_o   = IW'(sum);
  end

endmodule

// File: rtl/pic_priority_arbiter.sv
// rtl/pic_priority_arbiter.sv - rotating-priority interrupt resolver with ISR, OCW2 decode and INT/ACK handshake
module pic_priority_arbiter
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               ack,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_code,
  input  logic [IDX_W-1:0]   cmd_level,
  input  logic               auto_eoi,
  input  logic               special_fully_nested,
  input  logic               special_mask_mode,
  output logic               int_req,
  output logic [IDX_W-1:0]   int_idx,
  output logic [NUM_IRQ-1:0] isr,
  output logic [IDX_W-1:0]   lowest_prio,
  output logic               ack_spurious
);

  localparam logic [2**IDX_W-1:0] LVL_OK = (2**IDX_W)'((64'd1 << NUM_IRQ) - 64'd1);

  state_e               state_q, state_d;
  logic                 int_req_q, int_req_d;
  logic [IDX_W-1:0]     int_idx_q, int_idx_d;
  logic [NUM_IRQ-1:0]   isr_q, isr_d;
  logic [IDX_W-1:0]     lowest_q, lowest_d;
  logic                 rot_aeoi_q, rot_aeoi_d;
  logic                 spur_q, spur_d;

  logic                 isr_found, win_found, lvl_ok;
  logic [IDX_W-1:0]     isr_top, win_idx;
  logic [NUM_IRQ-1:0]   allow, elig;
  logic [31:0]          allow_rot, allow_lvl;
  int                   hi, top_rank;

  pic_rot_prio_find #(.N(NUM_IRQ), .IW(IDX_W)) u_isr_find (
    .vec_i        (isr_q),
    .lowest_prio_i(lowest_q),
    .found_o      (isr_found),
    .idx_o        (isr_top)
  );

  // Blocking is computed in the rotated (rank) domain, then rotated back to level order.
  always_comb begin
    hi       = (int'(lowest_q) == NUM_IRQ - 1) ? 0 : int'(lowest_q) + 1;
    top_rank = int'(isr_top) - hi;
    if (top_rank < 0) top_rank = top_rank + NUM_IRQ;
    allow_rot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!isr_found || i < top_rank || (special_fully_nested && i == top_rank)) allow_rot[i] = 1'b1;
    end
    allow_lvl = rot_left(allow_rot, hi, NUM_IRQ);
    for (int i = 0; i < NUM_IRQ; i++) begin
      allow[i] = special_mask_mode ? ~isr_q[i] : allow_lvl[i];
    end
    elig = irr & ~imr & allow;
  end

  pic_rot_prio_find #(.N(NUM_IRQ), .IW(IDX_W)) u_req_find (
    .vec_i        (elig),
    .lowest_prio_i(lowest_q),
    .found_o      (win_found),
    .idx_o        (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    int_req_d  = int_req_q;
    int_idx_d  = int_idx_q;
    isr_d      = isr_q;
    lowest_d   = lowest_q;
    rot_aeoi_d = rot_aeoi_q;
    spur_d     = 1'b0;
    lvl_ok     = LVL_OK[cmd_level];

    if (cmd_valid) begin
      case (cmd_code)
        OCW2_NS_EOI:       if (isr_found) isr_d[isr_top] = 1'b0;
        OCW2_SP_EOI:       if (lvl_ok) isr_d[cmd_level] = 1'b0;
        OCW2_ROT_NS_EOI: begin
          if (isr_found) begin
            isr_d[isr_top] = 1'b0;
            lowest_d       = isr_top;
          end
        end
        OCW2_ROT_SP_EOI: begin
          if (lvl_ok) begin
            isr_d[cmd_level] = 1'b0;
            lowest_d         = cmd_level;
          end
        end
        OCW2_SET_PRIO:     if (lvl_ok) lowest_d = cmd_level;
        OCW2_SET_ROT_AEOI: rot_aeoi_d = 1'b1;
        OCW2_CLR_ROT_AEOI: rot_aeoi_d = 1'b0;
        OCW2_NOP:          ;
      endcase
    end

    // Ack is applied after the command so its ISR set and rotation take precedence.
    case (state_q)
      ST_IDLE: begin
        if (ack) begin
          spur_d = 1'b1;
        end else if (win_found) begin
          state_d   = ST_PEND;
          int_req_d = 1'b1;
          int_idx_d = win_idx;
        end
      end
      ST_PEND: begin
        if (ack) begin
          if (!auto_eoi)       isr_d[int_idx_q] = 1'b1;
          else if (rot_aeoi_d) lowest_d = int_idx_q;
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end else if (!win_found) begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end else begin
          int_idx_d = win_idx;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      int_req_q  <= 1'b0;
      int_idx_q  <= '0;
      isr_q      <= '0;
      lowest_q   <= IDX_W'(NUM_IRQ - 1);
      rot_aeoi_q <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_req_q  <= int_req_d;
      int_idx_q  <= int_idx_d;
      isr_q      <= isr_d;
      lowest_q   <= lowest_d;
      rot_aeoi_q <= rot_aeoi_d;
      spur_q     <= spur_d;
    end
  end

  assign int_req      = int_req_q;
  assign int_idx      = int_idx_q;
  assign isr          = isr_q;
  assign lowest_prio  = lowest_q;
  assign ack_spurious = spur_q;

endmodule

// File: tb/tb_pic_priority_arbiter.sv
// tb/tb_pic_priority_arbiter.sv - self-checking bench: directed vector table, NUM_IRQ=5 sequence, randomized model compare
module tb_pic_priority_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n8, ack8, cv8, aeoi8, sfnm8, smm8;
  logic [7:0] irr8, imr8;
  logic [2:0] code8, lvl8;
  logic       req8, spur8;
  logic [2:0] idx8, low8;
  logic [7:0] isr8;

  logic       rst_n5, ack5, cv5;
  logic [4:0] irr5, isr5;
  logic [2:0] code5, lvl5, idx5, low5;
  logic       req5, spur5;

  pic_priority_arbiter dut8 (
    .clk(clk), .rst_n(rst_n8), .irr(irr8), .imr(imr8), .ack(ack8),
    .cmd_valid(cv8), .cmd_code(code8), .cmd_level(lvl8), .auto_eoi(aeoi8),
    .special_fully_nested(sfnm8), .special_mask_mode(smm8),
    .int_req(req8), .int_idx(idx8), .isr(isr8), .lowest_prio(low8), .ack_spurious(spur8)
  );

  pic_priority_arbiter #(.NUM_IRQ(5)) dut5 (
    .clk(clk), .rst_n(rst_n5), .irr(irr5), .imr(5'b0), .ack(ack5),
    .cmd_valid(cv5), .cmd_code(code5), .cmd_level(lvl5), .auto_eoi(1'b0),
    .special_fully_nested(1'b0), .special_mask_mode(1'b0),
    .int_req(req5), .int_idx(idx5), .isr(isr5), .lowest_prio(low5), .ack_spurious(spur5)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] irr, imr;
    logic       ack, cv;
    logic [2:0] code, lvl;
    logic       ae, sf, sm;
    logic       req;
    logic [2:0] idx;
    logic [7:0] isr;
    logic [2:0] low;
    logic       spur;
  } vec_t;

  function automatic vec_t mk(input int irr, imr, a, cv, cd, lv, ae, sf, sm,
                              input int req, idx, isrv, low, spur);
    vec_t v;
    v.irr = 8'(irr); v.imr = 8'(imr); v.ack = 1'(a); v.cv = 1'(cv);
    v.code = 3'(cd); v.lvl = 3'(lv); v.ae = 1'(ae); v.sf = 1'(sf); v.sm = 1'(sm);
    v.req = 1'(req); v.idx = 3'(idx); v.isr = 8'(isrv); v.low = 3'(low); v.spur = 1'(spur);
    return v;
  endfunction

  // Reference model for NUM_IRQ=8: priority rank 0 is the level just after lowest_prio.
  logic [7:0] m_isr;
  int         m_low, m_idx;
  bit         m_rot, m_pend, m_spur;

  function automatic int m_rank(input int lvl);
    return (lvl - m_low - 1 + 16) % 8;
  endfunction

  function automatic int m_top();
    int t = -1;
    for (int l = 0; l < 8; l++)
      if (m_isr[l] && (t < 0 || m_rank(l) < m_rank(t))) t = l;
    return t;
  endfunction

  function automatic int m_winner(input logic [7:0] rq, input logic [7:0] mk_, input bit sf, input bit sm);
    int t = m_top();
    int best = -1;
    bit ok;
    for (int l = 0; l < 8; l++) begin
      if (sm) ok = !m_isr[l];
      else    ok = (t < 0) || (m_rank(l) < m_rank(t)) || (sf && l == t);
      if (rq[l] && !mk_[l] && ok && (best < 0 || m_rank(l) < m_rank(best))) best = l;
    end
    return best;
  endfunction

  task automatic model_step(input logic [7:0] rq, input logic [7:0] mk_, input bit a, input bit cv,
                            input logic [2:0] cd, input logic [2:0] lv, input bit ae, input bit sf, input bit sm);
    logic [7:0] n_isr;
    int n_low, w, tgt;
    bit n_rot;
    n_isr = m_isr; n_low = m_low; n_rot = m_rot;
    w = m_winner(rq, mk_, sf, sm);
    if (cv) begin
      if (cd == 3'b100)      n_rot = 1'b1;
      else if (cd == 3'b000) n_rot = 1'b0;
      else if (cd == 3'b110) n_low = int'(lv);
      else if (cd[0]) begin
        tgt = cd[1] ? int'(lv) : m_top();
        if (tgt >= 0) begin
          n_isr[tgt] = 1'b0;
          if (cd[2]) n_low = tgt;
        end
      end
    end
    m_spur = 1'b0;
    if (m_pend) begin
      if (a) begin
        if (!ae) n_isr[m_idx] = 1'b1;
        else if (n_rot) n_low = m_idx;
        m_pend = 1'b0;
      end else if (w < 0) m_pend = 1'b0;
      else m_idx = w;
    end else if (a) m_spur = 1'b1;
    else if (w >= 0) begin
      m_pend = 1'b1;
      m_idx  = w;
    end
    m_isr = n_isr; m_low = n_low; m_rot = n_rot;
  endtask

  task automatic step5(input int rq, input int a, input int c, input int cd, input int lv);
    irr5 = 5'(rq); ack5 = 1'(a); cv5 = 1'(c); code5 = 3'(cd); lvl5 = 3'(lv);
    @(posedge clk); #1;
  endtask

  vec_t       tbl[$];
  logic [7:0] r_irr, r_imr;
  logic [2:0] r_cd, r_lv;
  bit         r_a, r_cv, r_ae, r_sf, r_sm;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n8 = 1'b0; rst_n5 = 1'b0;
    irr8 = '0; imr8 = '0; ack8 = 0; cv8 = 0; code8 = '0; lvl8 = '0; aeoi8 = 0; sfnm8 = 0; smm8 = 0;
    irr5 = '0; ack5 = 0; cv5 = 0; code5 = '0; lvl5 = '0;
    #12;
    chk("rst8.req", req8, 0); chk("rst8.idx", idx8, 0); chk("rst8.isr", isr8, 0);
    chk("rst8.low", low8, 7); chk("rst8.spur", spur8, 0);
    rst_n8 = 1'b1;

    //        irr   imr ack cv cd lv ae sf sm | req idx isr  low spur
    tbl.push_back(mk(8'h28, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 8'h00, 7, 0));
    tbl.push_back(mk(8'h28, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h08, 7, 0));
    tbl.push_back(mk(8'h20, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h08, 7, 0));
    tbl.push_back(mk(8'h20, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h08, 7, 0));
    tbl.push_back(mk(8'h22, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 8'h08, 7, 0));
    tbl.push_back(mk(8'h22, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h0A, 7, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 8'h08, 7, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 3, 3, 0, 0, 0,  0, 0, 8'h00, 7, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 6, 4, 0, 0, 0,  0, 0, 8'h00, 4, 0));
    tbl.push_back(mk(8'h21, 0, 0, 0, 0, 0, 0, 0, 0,  1, 5, 8'h00, 4, 0));
    tbl.push_back(mk(8'h21, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h20, 4, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 5, 0, 0, 0, 0,  0, 0, 8'h00, 5, 0));
    tbl.push_back(mk(8'h01, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 5, 0));
    tbl.push_back(mk(8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 5, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 5, 0, 0, 0, 0,  0, 0, 8'h00, 5, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 4, 0, 1, 0, 0,  0, 0, 8'h00, 5, 0));
    tbl.push_back(mk(8'h04, 0, 0, 0, 0, 0, 1, 0, 0,  1, 2, 8'h00, 5, 0));
    tbl.push_back(mk(8'h04, 0, 1, 0, 0, 0, 1, 0, 0,  0, 0, 8'h00, 2, 0));
    tbl.push_back(mk(8'h00, 0, 1, 0, 0, 0, 1, 0, 0,  0, 0, 8'h00, 2, 1));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 8'h00, 2, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 6, 7, 0, 0, 0,  0, 0, 8'h00, 7, 0));
    tbl.push_back(mk(8'h04, 0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 8'h00, 7, 0));
    tbl.push_back(mk(8'h04, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h04, 7, 0));
    tbl.push_back(mk(8'h04, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h04, 7, 0));
    tbl.push_back(mk(8'h04, 0, 0, 0, 0, 0, 0, 1, 0,  1, 2, 8'h04, 7, 0));
    tbl.push_back(mk(8'h00, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 8'h04, 7, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 3, 2, 0, 0, 0,  0, 0, 8'h00, 7, 0));
    tbl.push_back(mk(8'h01, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 7, 0));
    tbl.push_back(mk(8'h01, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h01, 7, 0));
    tbl.push_back(mk(8'h81, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h01, 7, 0));
    tbl.push_back(mk(8'h81, 0, 0, 0, 0, 0, 0, 0, 1,  1, 7, 8'h01, 7, 0));
    tbl.push_back(mk(8'h81, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 8'h81, 7, 0));
    tbl.push_back(mk(8'h08, 0, 0, 0, 0, 0, 0, 0, 1,  1, 3, 8'h81, 7, 0));
    tbl.push_back(mk(8'h08, 0, 1, 1, 3, 3, 0, 0, 1,  0, 0, 8'h89, 7, 0));
    tbl.push_back(mk(8'h10, 8'h10, 0, 0, 0, 0, 0, 0, 1,  0, 0, 8'h89, 7, 0));
    tbl.push_back(mk(8'h10, 0, 0, 0, 0, 0, 0, 0, 1,  1, 4, 8'h89, 7, 0));

    foreach (tbl[i]) begin
      irr8 = tbl[i].irr; imr8 = tbl[i].imr; ack8 = tbl[i].ack; cv8 = tbl[i].cv;
      code8 = tbl[i].code; lvl8 = tbl[i].lvl; aeoi8 = tbl[i].ae; sfnm8 = tbl[i].sf; smm8 = tbl[i].sm;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.req", i), req8, tbl[i].req);
      if (tbl[i].req) chk($sformatf("vec%0d.idx", i), idx8, tbl[i].idx);
      chk($sformatf("vec%0d.isr", i), isr8, tbl[i].isr);
      chk($sformatf("vec%0d.low", i), low8, tbl[i].low);
      chk($sformatf("vec%0d.spur", i), spur8, tbl[i].spur);
    end
    irr8 = '0; imr8 = '0; ack8 = 0; cv8 = 0; aeoi8 = 0; sfnm8 = 0; smm8 = 0;

    // NUM_IRQ=5: wrap-around, out-of-range levels, async reset while pending
    chk("n5.rst_low", low5, 4); chk("n5.rst_req", req5, 0);
    rst_n5 = 1'b1;
    step5(0, 1, 0, 0, 0);        chk("n5.first_ack_spur", spur5, 1); chk("n5.first_ack_req", req5, 0);
    step5(0, 0, 1, 6, 3);        chk("n5.setprio3", low5, 3); chk("n5.spur_clear", spur5, 0);
    step5(5'h11, 0, 0, 0, 0);    chk("n5.req_a", req5, 1); chk("n5.idx_a", idx5, 4);
    step5(5'h11, 1, 0, 0, 0);    chk("n5.isr_ack", isr5, 5'h10); chk("n5.req_ack", req5, 0);
    step5(0, 0, 1, 6, 6);        chk("n5.setprio_oor", low5, 3);
    step5(0, 0, 1, 3, 7);        chk("n5.speoi_oor", isr5, 5'h10);
    step5(0, 0, 1, 6, 4);        chk("n5.setprio4", low5, 4);
    step5(5'h03, 0, 0, 0, 0);    chk("n5.wrap_req", req5, 1); chk("n5.wrap_idx", idx5, 0);
    step5(5'h02, 0, 0, 0, 0);    chk("n5.follow_idx", idx5, 1); chk("n5.follow_req", req5, 1);
    rst_n5 = 1'b0;
    #1;
    chk("n5.arst_req", req5, 0); chk("n5.arst_idx", idx5, 0); chk("n5.arst_isr", isr5, 0);
    chk("n5.arst_low", low5, 4); chk("n5.arst_spur", spur5, 0);
    irr5 = '0;

    // Randomized run against the reference model
    rst_n8 = 1'b0;
    #2;
    rst_n8 = 1'b1;
    m_isr = '0; m_low = 7; m_idx = 0; m_rot = 0; m_pend = 0; m_spur = 0;
    r_ae = 0; r_sf = 0; r_sm = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) begin
        r_ae = ($urandom_range(0, 2) == 0);
        r_sf = ($urandom_range(0, 1) == 1);
        r_sm = ($urandom_range(0, 2) == 0);
      end
      r_irr = 8'($urandom) & 8'($urandom);
      r_imr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      r_a   = ($urandom_range(0, 2) == 0);
      r_cv  = ($urandom_range(0, 3) == 0);
      r_cd  = 3'($urandom);
      r_lv  = 3'($urandom);
      irr8 = r_irr; imr8 = r_imr; ack8 = r_a; cv8 = r_cv; code8 = r_cd; lvl8 = r_lv;
      aeoi8 = r_ae; sfnm8 = r_sf; smm8 = r_sm;
      model_step(r_irr, r_imr, r_a, r_cv, r_cd, r_lv, r_ae, r_sf, r_sm);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d.req", c), req8, int'(m_pend));
      chk($sformatf("rnd%0d.idx", c), idx8, m_idx);
      chk($sformatf("rnd%0d.isr", c), isr8, int'(m_isr));
      chk($sformatf("rnd%0d.low", c), low8, m_low);
      chk($sformatf("rnd%0d.spur", c), spur8, int'(m_spur));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pic_priority_arbiter.md
# pic_priority_arbiter

Parametrised, registered successor to the 8259A priority resolver: arbitrates `NUM_IRQ` interrupt requests under rotating priority, owns the in-service register (ISR), and runs a request/acknowledge handshake toward the CPU-interface block. It also decodes OCW2-style EOI/rotation commands, supports automatic EOI, special fully nested mode and special mask mode. It sits between the IRR/IMR registers and the INTA sequencer.

## Interface
- `NUM_IRQ`, 8: number of request lines (2..32).
- `IDX_W`, `$clog2(NUM_IRQ)`: level index width.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `irr` in NUM_IRQ: pending requests from IRR.
- `imr` in NUM_IRQ: mask, 1 = masked.
- `ack` in 1: one-cycle pulse; CPU accepts the presented vector.
- `cmd_valid` in 1: one-cycle strobe for `cmd_code`/`cmd_level`.
- `cmd_code` in 3: OCW2 {R,SL,EOI}.
- `cmd_level` in IDX_W: level for specific commands; ≥NUM_IRQ ignored.
- `auto_eoi` in 1: ISR bit not set on ack.
- `special_fully_nested` in 1: in-service level may be re-requested.
- `special_mask_mode` in 1: only in-service levels blocked.
- `int_req` out 1: interrupt pending toward CPU.
- `int_idx` out IDX_W: winning level, valid while `int_req`=1.
- `isr` out NUM_IRQ: in-service register.
- `lowest_prio` out IDX_W: current lowest-priority level.
- `ack_spurious` out 1: one-cycle pulse, ack with `int_req`=0.

## Operation
- Priority order: level `(lowest_prio+1) mod NUM_IRQ` highest, descending cyclically to `lowest_prio`.
- Eligible = `irr & ~imr`, then blocked by ISR:
  - normal: levels of priority ≤ highest ISR level blocked;
  - SFNM: only strictly lower levels blocked;
  - SMM (overrides both): only levels whose ISR bit is set blocked.
- Winner = highest-priority eligible level.
- FSM, states IDLE, PEND:
  - IDLE: winner exists → latch `int_idx`, `int_req`=1, go PEND.
  - PEND: re-arbitrate every cycle; `int_idx` follows the current winner.
  - PEND, no winner (request withdrawn or masked) → `int_req`=0, IDLE.
  - PEND, `ack` → `int_req`=0, IDLE.
- Effect of ack:
  - `auto_eoi`=0: set `isr[int_idx]`.
  - `auto_eoi`=1: ISR unchanged; if rotate-in-AEOI flag set, `lowest_prio`←`int_idx`.
- `ack` in IDLE: no state change, `ack_spurious` pulses.
- `cmd_code` on `cmd_valid`:
  - 001: clear highest-priority ISR bit.
  - 011: clear `isr[cmd_level]`.
  - 101: clear highest ISR bit; `lowest_prio`←that level.
  - 111: clear `isr[cmd_level]`; `lowest_prio`←`cmd_level`.
  - 110: `lowest_prio`←`cmd_level`.
  - 100: set rotate-in-AEOI flag.
  - 000: clear rotate-in-AEOI flag.
  - 010: no-op.
  - Non-specific with ISR=0: no-op, no rotation.
- Same cycle: commands update ISR/rotation first, then ack applies.
  - If both target the same bit, ack's set wins.
  - If both rotate, ack's rotation wins.

## Timing
- Reset (async assert, sync release): `isr`=0, `lowest_prio`=NUM_IRQ-1 (level 0 highest), `int_req`=0, `int_idx`=0, `ack_spurious`=0, rotate-in-AEOI flag=0, state IDLE.
- Reset mid-handshake aborts; an `ack` in the first cycle after release is spurious.
- Request in cycle t (inputs sampled at edge t) → `int_req`=1 after edge t.
- Ack sampled at edge t → `isr`/`lowest_prio` updated and `int_req`=0 after edge t.
- Next `int_req` earliest after edge t+1 (one IDLE cycle).
- Commands take effect at the sampling edge; arbitration sees the new ISR on the next edge.
- Wrap-around: level NUM_IRQ-1 → level 0 in priority order; `lowest_prio` arithmetic is mod NUM_IRQ, correct for non-power-of-two NUM_IRQ.

## Structure
- Shared package `pic_pkg`:
  - localparams for OCW2 command codes;
  - FSM state typedef;
  - rotate-left/rotate-right functions parametrised on width.
- One sub-module, `pic_rot_prio_find`, combinational.
  - Inputs: vector, `lowest_prio`. Outputs: found flag, index.
  - Instantiated twice: eligible requests, and ISR (highest in-service level).

## Test plan
- Reset, `irr`=0x28, `imr`=0 → `int_req`=1 next cycle, `int_idx`=3; ack → `isr`=0x08, `int_req`=0; `irr[5]` alone held → no new request (normal nesting).
- ISR=0x08, raise `irr[1]` → `int_idx`=1; ack → `isr`=0x0A; command 001 → `isr`=0x08.
- Command 110 level 4 → `lowest_prio`=4; `irr`=0x21 → `int_idx`=5; command 101 after ack → `isr`=0, `lowest_prio`=5; `irr`=0x01 → `int_idx`=0.
- `auto_eoi`=1, command 100, `irr`=0x04, ack → `isr`=0, `lowest_prio`=2; ack while IDLE → `ack_spurious` pulse, no state change.
- `isr`=0x04; SFNM re-request of level 2 → granted; SMM with `isr`=0x01, `irr`=0x81 → `int_idx`=7; same-cycle ack of level 3 and command 011 level 3 → `isr[3]`=1.
- NUM_IRQ=5: command 110 level 4 → level 0 highest; `rst_n` low while PEND → all outputs at reset values immediately.
